// File: rtl/sr_latch_driver_pkg.sv
// Shared definitions for the SR NAND latch driver: FSM state encoding and
// parameter helpers used to size the width counter and validate settings.
package sr_latch_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_CHECK = 2'd3
    } state_e;

    // Larger of two integers, used to size the shared width counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // A pulse must last at least one cycle; the gap may be skipped entirely.
    function automatic bit params_legal(input int pulse_w, input int gap_w);
        return (pulse_w >= 1) && (gap_w >= 0);
    endfunction

endpackage

// File: rtl/sr_latch_driver_sync_2ff.sv
// Two-flop synchroniser bringing the asynchronous latch Q into the clk domain.
module sync_2ff
    import sr_latch_driver_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic ff1_q;
    logic ff2_q;

    // Shift the asynchronous input through two flops; both clear on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
        end else begin
            ff1_q <= d_i;
            ff2_q <= ff1_q;
        end
    end

    assign q_o = ff2_q;

endmodule

// File: rtl/sr_latch_driver.sv
// Clocked front end for an asynchronous SR NAND latch. Each accepted request
// becomes a fixed-width active-low pulse on s_n or r_n (never both), followed
// by an optional quiet gap and a one-cycle check of the synchronised latch Q.
module sr_latch_driver
    import sr_latch_driver_pkg::*;
#(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_set,
    output logic req_ready,
    output logic s_n,
    output logic r_n,
    input  logic q_in,
    output logic busy,
    output logic done,
    output logic err
);

    localparam int CNT_W = $clog2(max_int(PULSE_W, GAP_W) + 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_W > 0) ? (GAP_W - 1) : 0);
    localparam logic             HAS_GAP    = (GAP_W > 0) ? 1'b1 : 1'b0;

    if (!params_legal(PULSE_W, GAP_W)) begin : g_bad_params
        $error("sr_latch_driver: PULSE_W must be >= 1 and GAP_W >= 0");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             s_n_q, s_n_d;
    logic             r_n_q, r_n_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             q_sync_s;

    sync_2ff u_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (q_in),
        .q_o   (q_sync_s)
    );

    // Next-state, counter reload and next-output decode. Outputs are derived
    // from the next state so that the registered pins line up with the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_PULSE;
                    cnt_d   = PULSE_LAST;
                    dir_d   = req_set;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (HAS_GAP) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LAST;
                end else begin
                    state_d = ST_CHECK;
                    cnt_d   = '0;
                end
            end
            ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_CHECK;
                    cnt_d   = '0;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Only one of s_n/r_n can ever be selected: both depend on one dir bit.
        s_n_d   = ~((state_d == ST_PULSE) &  dir_d);
        r_n_d   = ~((state_d == ST_PULSE) & ~dir_d);
        done_d  = (state_d == ST_CHECK);
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
        // Mismatch is judged on q_sync during the CHECK cycle; err is sticky.
        err_d   = err_q | ((state_q == ST_CHECK) & (q_sync_s != dir_q));
    end

    // State, counter, direction and all output registers; reset forces the
    // latch inputs inactive and drops any in-flight request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            s_n_q   <= 1'b1;
            r_n_q   <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            s_n_q   <= s_n_d;
            r_n_q   <= r_n_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign s_n       = s_n_q;
    assign r_n       = r_n_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign req_ready = ready_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench: driver -> behavioural NAND latch -> q_in, with a timeline reference
// model, a directed vector table and hand-written abort/back-to-back cases.
module tb_sr_latch_driver;

    localparam int P = 2;
    localparam int G = 1;

    logic clk = 1'b0;
    logic rst;
    logic req_valid;
    logic req_set;
    logic req_ready;
    logic s_n;
    logic r_n;
    logic q_in;
    logic busy;
    logic done;
    logic err;
    logic fault;
    logic lq = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // reference model state: request timeline expressed as accept cycle + offset
    bit m_active = 1'b0;
    int m_a      = 0;
    bit m_dir    = 1'b0;
    bit m_err    = 1'b0;

    sr_latch_driver #(.PULSE_W(P), .GAP_W(G)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_set   (req_set),
        .req_ready (req_ready),
        .s_n       (s_n),
        .r_n       (r_n),
        .q_in      (q_in),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // behavioural SR NAND latch; pulses are never overlapping so edges suffice
    always @(negedge s_n or negedge r_n) begin
        if (!s_n) lq <= 1'b1;
        else      lq <= 1'b0;
    end

    assign q_in = fault ? 1'b0 : lq;

    function automatic bit m_idle(input int c);
        return !m_active || ((c - m_a) >= (P + G + 1));
    endfunction

    // model update on each rising edge
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_active <= 1'b0;
            m_err    <= 1'b0;
        end else begin
            if (m_active && ((cyc - m_a) == (P + G)) && (q_in != m_dir))
                m_err <= 1'b1;
            if (m_idle(cyc) && req_valid) begin
                m_active <= 1'b1;
                m_a      <= cyc + 1;
                m_dir    <= req_set;
            end
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic check_model();
        int  off;
        bit  act, in_pulse;
        off      = cyc - m_a;
        act      = m_active && (off >= 0) && (off <= P + G);
        in_pulse = act && (off < P);
        chk("s_n",       s_n,       !(in_pulse && m_dir));
        chk("r_n",       r_n,       !(in_pulse && !m_dir));
        chk("busy",      busy,      act);
        chk("req_ready", req_ready, !act);
        chk("done",      done,      act && (off == P + G));
        chk("err",       err,       m_err);
        chk("never_both_low", s_n | r_n, 1'b1);
    endtask

    task automatic tick();
        @(negedge clk);
        if (chk_en) check_model();
    endtask

    typedef struct {
        logic set;
        logic flt;
        logic exp_q;
        logic exp_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int  a_cyc, d_cyc, nacc, last, got;
        logic nxt;

        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1};

        rst = 1'b1; req_valid = 1'b0; req_set = 1'b0; fault = 1'b0;
        tick(); tick();
        chk("rst_s_n", s_n, 1'b1);
        chk("rst_r_n", r_n, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_ready", req_ready, 1'b1);
        rst = 1'b0;
        chk_en = 1'b1;
        tick();

        // directed vectors: set/reset, redundant requests, fault and sticky err
        for (int i = 0; i < 8; i++) begin
            fault = vecs[i].flt;
            req_valid = 1'b1;
            req_set = vecs[i].set;
            got = 0;
            for (int w = 0; w < 20; w++) begin
                tick();
                if (req_ready) begin got = 1; break; end
            end
            chk_int("accept_timeout", got, 1);
            tick();
            a_cyc = cyc;
            req_valid = 1'b0;
            d_cyc = -1;
            for (int w = 0; w < 20; w++) begin
                tick();
                if (done) begin d_cyc = cyc; break; end
            end
            chk_int("done_latency", d_cyc - a_cyc, P + G);
            tick();
            fault = 1'b0;
            chk("latch_q", lq, vecs[i].exp_q);
            chk("err_after", err, vecs[i].exp_err);
        end

        // err only clears on reset
        rst = 1'b1; tick(); rst = 1'b0;
        chk("err_cleared", err, 1'b0);
        tick();

        // back-to-back with req_valid held: accept every P+G+2 cycles
        req_valid = 1'b1; nxt = 1'b1; last = -1; nacc = 0;
        for (int i = 0; i < 26; i++) begin
            tick();
            if (req_ready) begin
                if (last >= 0) chk_int("b2b_interval", cyc - last, P + G + 2);
                last = cyc;
                req_set = nxt;
                nxt = ~nxt;
                nacc++;
            end
        end
        chk_int("b2b_count", (nacc >= 5) ? 1 : 0, 1);
        req_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // abort: reset during the second PULSE cycle
        req_valid = 1'b1; req_set = 1'b1;
        for (int w = 0; w < 10; w++) begin
            tick();
            if (req_ready) break;
        end
        tick();
        req_valid = 1'b0;
        chk("abort_pulse0", s_n, 1'b0);
        tick();
        chk("abort_pulse1", s_n, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_s_n", s_n, 1'b1);
        chk("abort_r_n", r_n, 1'b1);
        chk("abort_busy", busy, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_done", done, 1'b0);
        end

        // rst and req_valid together: rst wins
        rst = 1'b1; req_valid = 1'b1; req_set = 1'b0;
        tick();
        rst = 1'b0; req_valid = 1'b0;
        chk("rst_wins_busy", busy, 1'b0);
        tick();
        chk("rst_wins_idle", busy, 1'b0);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            req_valid = ($urandom_range(0, 9) < 7);
            req_set   = 1'($urandom_range(0, 1));
            rst       = ($urandom_range(0, 99) < 2);
            tick();
        end
        rst = 1'b0; req_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
